// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : clocked, parametrised ALU with valid/ready handshakes.
//
// Add, subtract, the bitwise ops and the shifts finish on the accepting
// edge. Multiply (shift-add) and divide (restoring) take one accepting
// edge plus WIDTH BUSY cycles. The result is held in DONE until the
// consumer takes it.
//
// Optional feature: define ALU_OVERFLOW_EN to get the signed 'overflow'
// output for ADD/SUB. Without it the port and its logic are absent.
// ---------------------------------------------------------------------------
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         opcode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic [WIDTH-1:0]   remainder,
   output logic               carry_out,
   output logic               zero,
   output logic               error
`ifdef ALU_OVERFLOW_EN
   ,
   output logic               overflow
`endif
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NAND = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_XNOR = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;

   // Shift amounts at or beyond this value flush the operand to zero.
   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);
   // Counter value on which the last iterative step is taken.
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_reg;
   state_t             state_next;
   logic               ready_en_reg;

   // Operands latched on the accepting edge
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [3:0]         op_reg;

   // Iterative engine: hi/lo hold partial product/multiplier for MUL and
   // partial remainder/quotient for DIV.
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   work_hi_reg;
   logic [WIDTH-1:0]   work_lo_reg;

   // Registered results
   logic [2*WIDTH-1:0] result_reg;
   logic [WIDTH-1:0]   remainder_reg;
   logic               carry_reg;
   logic               zero_reg;
   logic               error_reg;
`ifdef ALU_OVERFLOW_EN
   logic               overflow_reg;
   logic               sc_overflow;
`endif

   logic               accept;
   logic               iterative;
   logic               busy_last;

   // Single-cycle datapath
   logic [WIDTH:0]     sum_ext;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   and_bits;
   logic [WIDTH-1:0]   or_bits;
   logic [WIDTH-1:0]   xor_bits;
   logic [WIDTH-1:0]   sc_low;
   logic [WIDTH-1:0]   sc_rem;
   logic               sc_carry;
   logic               sc_error;

   // Iterative step datapath
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_next;
   logic [WIDTH-1:0]   mul_lo_next;
   logic [WIDTH:0]     div_shift;
   logic               div_neg;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   div_rem_next;
   logic [WIDTH-1:0]   div_quot_next;

   assign accept    = in_valid && in_ready;
   // Divide by zero is resolved immediately, so it never enters BUSY.
   assign iterative = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));
   assign busy_last = (cnt_reg == LAST_STEP);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register; ready_en delays in_ready by one edge after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_IDLE;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         ready_en_reg <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next = iterative ? S_BUSY : S_DONE;
            end
         end
         S_BUSY: begin
            if (busy_last) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state
   always_comb begin
      in_ready  = (state_reg == S_IDLE) && ready_en_reg;
      out_valid = (state_reg == S_DONE);
   end

   // ------------------------------------------------------------------
   // Single-cycle operations
   // ------------------------------------------------------------------

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
      assign xor_bits[gi] = a[gi] ^ b[gi];
   end

   assign sum_ext = {1'b0, a} + {1'b0, b};
   assign diff    = a - b;

   // Result and flags of every op that completes on the accepting edge
   always_comb begin
      sc_low   = '0;
      sc_rem   = '0;
      sc_carry = 1'b0;
      sc_error = 1'b0;
`ifdef ALU_OVERFLOW_EN
      sc_overflow = 1'b0;
`endif
      case (opcode)
         OP_ADD: begin
            sc_low   = sum_ext[WIDTH-1:0];
            sc_carry = sum_ext[WIDTH];
`ifdef ALU_OVERFLOW_EN
            sc_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a[WIDTH-1]);
`endif
         end
         OP_SUB: begin
            sc_low   = diff;
            sc_carry = (a < b);
`ifdef ALU_OVERFLOW_EN
            sc_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a[WIDTH-1]);
`endif
         end
         OP_MUL: begin
            // Completed by the iterative engine
            sc_low = '0;
         end
         OP_DIV: begin
            // Only reached here for b == 0
            sc_low   = '1;
            sc_rem   = a;
            sc_error = 1'b1;
         end
         OP_AND:  sc_low = and_bits;
         OP_OR:   sc_low = or_bits;
         OP_NOT:  sc_low = ~a;
         OP_XOR:  sc_low = xor_bits;
         OP_NAND: sc_low = ~and_bits;
         OP_NOR:  sc_low = ~or_bits;
         OP_XNOR: sc_low = ~xor_bits;
         OP_SHL:  sc_low = (b >= SHIFT_LIM) ? '0 : (a << b);
         OP_SHR:  sc_low = (b >= SHIFT_LIM) ? '0 : (a >> b);
         default: begin
            sc_low   = '0;
            sc_error = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Iterative operations
   // ------------------------------------------------------------------

   // One shift-add step (MUL) and one restoring step (DIV) per cycle
   always_comb begin
      mul_sum     = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, a_reg} : '0);
      mul_hi_next = mul_sum[WIDTH:1];
      mul_lo_next = {mul_sum[0], work_lo_reg[WIDTH-1:1]};

      div_shift     = {work_hi_reg, work_lo_reg[WIDTH-1]};
      div_neg       = (div_shift < {1'b0, b_reg});
      // When the trial subtraction succeeds the difference is below b,
      // so the low WIDTH bits are the exact new remainder.
      div_diff      = div_shift[WIDTH-1:0] - b_reg;
      div_rem_next  = div_neg ? div_shift[WIDTH-1:0] : div_diff;
      div_quot_next = {work_lo_reg[WIDTH-2:0], ~div_neg};
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= '0;
         cnt_reg       <= '0;
         work_hi_reg   <= '0;
         work_lo_reg   <= '0;
         result_reg    <= '0;
         remainder_reg <= '0;
         carry_reg     <= 1'b0;
         zero_reg      <= 1'b0;
         error_reg     <= 1'b0;
`ifdef ALU_OVERFLOW_EN
         overflow_reg  <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  a_reg   <= a;
                  b_reg   <= b;
                  op_reg  <= opcode;
                  cnt_reg <= '0;
                  if (iterative) begin
                     work_hi_reg <= '0;
                     work_lo_reg <= (opcode == OP_MUL) ? b : a;
                  end else begin
                     result_reg    <= {{WIDTH{1'b0}}, sc_low};
                     remainder_reg <= sc_rem;
                     carry_reg     <= sc_carry;
                     zero_reg      <= (sc_low == '0);
                     error_reg     <= sc_error;
`ifdef ALU_OVERFLOW_EN
                     overflow_reg  <= sc_overflow;
`endif
                  end
               end
            end
            S_BUSY: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (op_reg == OP_MUL) begin
                  work_hi_reg <= mul_hi_next;
                  work_lo_reg <= mul_lo_next;
               end else begin
                  work_hi_reg <= div_rem_next;
                  work_lo_reg <= div_quot_next;
               end
               // The last step writes its outcome straight into the result
               if (busy_last) begin
                  carry_reg <= 1'b0;
                  error_reg <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                  overflow_reg <= 1'b0;
`endif
                  if (op_reg == OP_MUL) begin
                     result_reg    <= {mul_hi_next, mul_lo_next};
                     remainder_reg <= '0;
                     zero_reg      <= ({mul_hi_next, mul_lo_next} == '0);
                  end else begin
                     result_reg    <= {{WIDTH{1'b0}}, div_quot_next};
                     remainder_reg <= div_rem_next;
                     zero_reg      <= (div_quot_next == '0);
                  end
               end
            end
            default: begin
               // DONE: everything holds under backpressure
            end
         endcase
      end
   end

   assign result    = result_reg;
   assign remainder = remainder_reg;
   assign carry_out = carry_reg;
   assign zero      = zero_reg;
   assign error     = error_reg;
`ifdef ALU_OVERFLOW_EN
   assign overflow  = overflow_reg;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu : directed bench for seq_alu (WIDTH=8). A behavioural model
// predicts each transaction; a negedge monitor checks the DUT outputs on
// every cycle out_valid is high. Define ALU_OVERFLOW_EN for the
// overflow checks.
// ---------------------------------------------------------------------------
module tb_seq_alu;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [3:0]     opcode;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] result;
   logic [W-1:0]   remainder;
   logic           carry_out;
   logic           zero;
   logic           error;
`ifdef ALU_OVERFLOW_EN
   logic           overflow;
`endif

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .remainder (remainder),
      .carry_out (carry_out),
      .zero      (zero),
      .error     (error)
`ifdef ALU_OVERFLOW_EN
      ,
      .overflow  (overflow)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] res;
      logic [W-1:0]   rem;
      logic           carry;
      logic           zero;
      logic           err;
      logic           ovf;
      int             lat;
      int             base;
      logic [3:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
   } exp_t;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc          = 0;
   exp_t q[$];
   bit   head_seen    = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      tests_run++;
      if (act != req) begin
         tests_failed++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Behavioural model: plain integer arithmetic on the operand values
   function automatic exp_t model(input int unsigned ai, input int unsigned bi,
                                  input logic [3:0] op);
      exp_t        e;
      int unsigned mask;
      int unsigned r;
      int          sa, sb, sr;
      e    = '{default: '0};
      mask = (1 << W) - 1;
      r    = 0;
      sa   = (ai >= (1 << (W-1))) ? int'(ai) - (1 << W) : int'(ai);
      sb   = (bi >= (1 << (W-1))) ? int'(bi) - (1 << W) : int'(bi);
      e.lat = 1;
      case (op)
         4'd0: begin
            r = ai + bi;  e.carry = (r > mask);  r = r & mask;
            sr = sa + sb; e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
         end
         4'd1: begin
            r = (ai - bi) & mask;  e.carry = (ai < bi);
            sr = sa - sb; e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
         end
         4'd2: begin r = ai * bi; e.lat = W + 1; end
         4'd3: begin
            if (bi == 0) begin r = mask; e.rem = W'(ai); e.err = 1'b1; end
            else begin r = ai / bi; e.rem = W'(ai % bi); e.lat = W + 1; end
         end
         4'd4:  r = ai & bi;
         4'd5:  r = ai | bi;
         4'd6:  r = ~ai & mask;
         4'd7:  r = ai ^ bi;
         4'd8:  r = ~(ai & bi) & mask;
         4'd9:  r = ~(ai | bi) & mask;
         4'd10: r = ~(ai ^ bi) & mask;
         4'd11: r = (bi >= W) ? 0 : ((ai << bi) & mask);
         4'd12: r = (bi >= W) ? 0 : (ai >> bi);
         default: begin r = 0; e.err = 1'b1; end
      endcase
      e.res  = (2*W)'(r);
      e.zero = (r == 0);
      e.op   = op;
      e.a    = W'(ai);
      e.b    = W'(bi);
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every cycle with an outstanding transaction
   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() != 0) check("in_ready_while_busy", in_ready, 0);
         if (out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out_valid", out_valid, 0);
            end else begin
               if (!head_seen) begin
                  check("latency", cyc - q[0].base, q[0].lat);
                  head_seen = 1'b1;
               end
               check("result", result, q[0].res);
               check("remainder", remainder, q[0].rem);
               check("flags_czE", {carry_out, zero, error}, {q[0].carry, q[0].zero, q[0].err});
`ifdef ALU_OVERFLOW_EN
               check("overflow", overflow, q[0].ovf);
`endif
               if (out_ready) begin
                  $display("[TB] txn op=%b a=%0d b=%0d result=0x%04h rem=%0d carry=%0b zero=%0b error=%0b",
                           q[0].op, q[0].a, q[0].b, result, remainder, carry_out, zero, error);
                  void'(q.pop_front());
                  head_seen = 1'b0;
               end
            end
         end
      end
   end

   // Issue one request; pins the model against hand-computed literals.
   // Called and returns at posedge+1.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [3:0] iop, input longint lit_res,
                        input longint lit_rem, input int lit_err, input int lit_lat);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", in_ready, 1);
      e      = model(ia, ib, iop);
      e.base = cyc;
      check("model_res", e.res, lit_res);
      check("model_rem", e.rem, lit_rem);
      check("model_err", e.err, lit_err);
      check("model_lat", e.lat, lit_lat);
      a = ia; b = ib; opcode = iop; in_valid = 1'b1;
      @(posedge clk); #1;
      // Operand changes after acceptance must have no effect
      in_valid = 1'b0; a = ~ia; b = ~ib; opcode = iop ^ 4'b0101;
      q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((q.size() != 0 || !in_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", q.size(), 0);
   endtask

   task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [3:0] iop, input longint lit_res,
                      input longint lit_rem, input int lit_err, input int lit_lat);
      issue(ia, ib, iop, lit_res, lit_rem, lit_err, lit_lat);
      wait_idle();
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_result"}, result, 0);
      check({tag, "_remainder"}, remainder, 0);
      check({tag, "_flags"}, {carry_out, zero, error}, 0);
`ifdef ALU_OVERFLOW_EN
      check({tag, "_overflow"}, overflow, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef ALU_OVERFLOW_EN
      exp_t t;
`endif
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; opcode = '0;
      #1;
      check_cleared("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("ready_before_edge", in_ready, 0);
      @(posedge clk); #1;
      check("ready_after_edge", in_ready, 1);

      // Single-cycle ops
      run(8'd200, 8'd100, 4'b0000, 16'h002C, 0, 0, 1);
      run(8'd5,   8'd9,   4'b0001, 16'h00FC, 0, 0, 1);
      run(8'd9,   8'd9,   4'b0001, 16'h0000, 0, 0, 1);
      run(8'd255, 8'd1,   4'b0000, 16'h0000, 0, 0, 1);
      run(8'hA0,  8'h05,  4'b0101, 16'h00A5, 0, 0, 1);
      run(8'h0F,  8'h00,  4'b0110, 16'h00F0, 0, 0, 1);
      run(8'hFF,  8'h0F,  4'b0111, 16'h00F0, 0, 0, 1);
      run(8'hF0,  8'h3C,  4'b1000, 16'h00CF, 0, 0, 1);
      run(8'hF0,  8'h0F,  4'b1001, 16'h0000, 0, 0, 1);
      run(8'hAA,  8'h0F,  4'b1010, 16'h005A, 0, 0, 1);
      run(8'h03,  8'd2,   4'b1011, 16'h000C, 0, 0, 1);
      run(8'h81,  8'd1,   4'b1011, 16'h0002, 0, 0, 1);
      run(8'hFF,  8'd8,   4'b1011, 16'h0000, 0, 0, 1);
      run(8'h80,  8'd7,   4'b1100, 16'h0001, 0, 0, 1);
      run(8'hFF,  8'd9,   4'b1100, 16'h0000, 0, 0, 1);
      run(8'd3,   8'd4,   4'b1110, 16'h0000, 0, 1, 1);
      run(8'd3,   8'd4,   4'b1101, 16'h0000, 0, 1, 1);
      run(8'd3,   8'd4,   4'b1111, 16'h0000, 0, 1, 1);

      // Iterative ops and divide by zero
      run(8'd200, 8'd150, 4'b0010, 16'h7530, 0, 0, 9);
      run(8'd255, 8'd255, 4'b0010, 16'hFE01, 0, 0, 9);
      run(8'd0,   8'd77,  4'b0010, 16'h0000, 0, 0, 9);
      run(8'd200, 8'd7,   4'b0011, 16'd28,   4, 0, 9);
      run(8'd7,   8'd200, 4'b0011, 16'd0,    7, 0, 9);
      run(8'd255, 8'd1,   4'b0011, 16'd255,  0, 0, 9);
      run(8'd55,  8'd0,   4'b0011, 16'h00FF, 55, 1, 1);

      // Backpressure: hold the AND result for 5 cycles, pulse in_valid
      out_ready = 1'b0;
      issue(8'hF0, 8'h3C, 4'b0100, 16'h0030, 0, 0, 1);
      repeat (2) begin @(posedge clk); #1; end
      a = 8'd1; b = 8'd1; opcode = 4'b0000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("held_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_idle();
      check("released_out_valid", out_valid, 0);

      // Reset in the middle of a multiply
      issue(8'd200, 8'd150, 4'b0010, 16'h7530, 0, 0, 9);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      q.delete();
      head_seen = 1'b0;
      #1 check_cleared("mid_mul_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1 check("ready_before_edge2", in_ready, 0);
      @(posedge clk); #1;
      check("ready_after_edge2", in_ready, 1);
      run(8'd1, 8'd1, 4'b0000, 16'h0002, 0, 0, 1);

`ifdef ALU_OVERFLOW_EN
      t = model(100, 100, 4'b0000);
      check("model_ovf_add", t.ovf, 1);
      run(8'd100, 8'd100, 4'b0000, 16'h00C8, 0, 0, 1);
      t = model(8'h80, 1, 4'b0001);
      check("model_ovf_sub", t.ovf, 1);
      run(8'h80, 8'd1, 4'b0001, 16'h007F, 0, 0, 1);
      t = model(8'h7F, 1, 4'b0001);
      check("model_no_ovf", t.ovf, 0);
      run(8'h7F, 8'd1, 4'b0001, 16'h007E, 0, 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the team's 4-bit combinational ALU.
- Operands are WIDTH bits wide and enter through a valid/ready handshake.
- Add, subtract, logic and shift operations complete in one cycle. Multiply (shift-add) and divide (restoring) are iterative over WIDTH cycles.
- Sits between the datapath register file and writeback; results are held under output backpressure.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- opcode  in  4  operation select.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  result, zero-extended except for MUL.
- remainder  out  WIDTH  DIV remainder; 0 for all other ops.
- carry_out  out  1  ADD carry / SUB borrow; 0 for all other ops.
- zero  out  1  result == 0.
- error  out  1  divide-by-zero or illegal opcode.
- overflow  out  1  signed overflow (only with ALU_OVERFLOW_EN).

Behaviour:
- Reset: clk and rst_n as stated; async, active-low. All outputs, state and operand registers clear to 0 and FSM enters IDLE. Reset mid-operation aborts the operation and drops its result. in_ready goes to 1 on the first clk edge after deassertion.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). A request is accepted on an edge where in_valid && in_ready; a, b and opcode are latched at that edge.
- Single-cycle ops (IDLE->DONE on the accepting edge):
  - 0000 ADD: result = a+b; carry_out = bit WIDTH of the sum; result holds only the low WIDTH bits.
  - 0001 SUB: result = (a-b) mod 2^WIDTH; carry_out = (a<b).
  - 0100 AND, 0101 OR, 0110 NOT a, 0111 XOR, 1000 NAND, 1001 NOR, 1010 XNOR: bitwise, WIDTH bits.
  - 1011 SHL / 1100 SHR: logical shift of a by b; result is 0 if b>=WIDTH.
  - 1101-1111: result 0, error 1.
- MUL 0010: IDLE->BUSY. One shift-add step per cycle for WIDTH cycles, then ->DONE. Full 2*WIDTH product, unsigned. out_valid rises WIDTH+1 edges after the accepting edge.
- DIV 0011: IDLE->BUSY. One restoring step per cycle for WIDTH cycles, then ->DONE. Unsigned. quotient goes in result[WIDTH-1:0] and the remainder on remainder. Latency WIDTH+1 edges.
- DIV with b==0: no BUSY phase; IDLE->DONE in 1 edge. quotient all ones, remainder = a, error 1.
- DONE: out_valid=1; result and all flags are stable and unchanged while out_ready=0. On an edge with out_valid && out_ready: ->IDLE, out_valid->0. Result registers keep their values until the next completion.
- in_valid while busy: ignored, no queuing. Opcode or operand changes after acceptance have no effect.
- zero is computed on the final result; for DIV it reflects the quotient only.
- No back-to-back issue: minimum initiation interval is 2 cycles for single-cycle ops and WIDTH+2 for MUL/DIV.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined: overflow port present. It is set on ADD when a and b have equal sign bits and the sign of result[WIDTH-1] differs. It is set on SUB when a and b have different sign bits and the sign of result[WIDTH-1] differs from a. It is 0 for all other ops, cleared by reset, and registered with the result.
- Undefined: overflow port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- ADD a=200,b=100 -> result 0x002C, carry_out 1, zero 0, out_valid 1 edge after accept.
- SUB a=5,b=9 -> result 0x00FC, carry_out 1; SUB a=9,b=9 -> result 0, zero 1, carry_out 0.
- MUL a=200,b=150 -> result 0x7530, out_valid exactly 9 edges after accept, in_ready 0 throughout; MUL a=255,b=255 -> 0xFE01.
- DIV a=200,b=7 -> result 28, remainder 4, 9-edge latency. DIV a=55,b=0 -> result 0x00FF, remainder 55, error 1, 1-edge latency. Opcode 1110 -> result 0, error 1.
- Backpressure: hold out_ready=0 for 5 cycles after an AND with a=0xF0,b=0x3C -> result 0x0030 stable, in_ready 0, and an in_valid pulse is ignored; out_ready=1 -> IDLE next edge.
- Assert rst_n=0 mid-MUL (cycle 4) -> all outputs 0 immediately; after release a new ADD 1+1 -> result 2. With ALU_OVERFLOW_EN: ADD 100+100 -> overflow 1; SUB 0x80-1 -> overflow 1.
